// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory read by the fetch stage.
// It takes a byte stream from a host or debug source over a valid/ready
// handshake. The stream is:
//   - a 16-bit little-endian word count N;
//   - N little-endian 32-bit instruction words.
// Each word is written to BASE_ADDR + 4*index. The CPU is held in reset until
// a complete image has been loaded.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   After the last word (or straight after an N==0 header), one more byte is
//   accepted. It must equal the XOR of every data byte; the header bytes are
//   not included. A match ends in DONE and a mismatch ends in ERROR. Words
//   already written stay written. Without the macro there is no CHECK state
//   and no XOR register.
//
// Parameters
//   ADDR_WIDTH  width of mem_addr (byte address, same as PC width)
//   MEM_DEPTH   instruction memory depth in 32-bit words; max loadable count
//   BASE_ADDR   byte address of the first word written (must be 4-aligned)
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   1-cycle pulse; begins a load from IDLE/DONE/ERROR only
//   byte_valid    in   byte_data is valid
//   byte_data     in   stream byte
//   byte_ready    out  loader accepts a byte this cycle (HDR/LOAD/CHECK)
//   mem_we        out  instruction memory write strobe, one cycle per word
//   mem_addr      out  byte address of the write (BASE_ADDR + 4*index)
//   mem_wdata     out  instruction word being written
//   cpu_hold      out  1 = keep the pipeline/PC in reset
//   busy          out  load in progress
//   done          out  image loaded successfully (level until next start)
//   error         out  load aborted (level until next start)
//   words_loaded  out  number of words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           MEM_DEPTH  = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      ST_CHECK = 3'd6
`endif
   } state_t;

   // State that follows the final word (or an empty image).
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t ST_AFTER_LAST = ST_CHECK;
`else
   localparam state_t ST_AFTER_LAST = ST_DONE;
`endif

   // The count is compared in 17 bits. This keeps MEM_DEPTH == 65536 meaningful.
   localparam logic [16:0] DEPTH_LIMIT = 17'(MEM_DEPTH);

   state_t        state_reg;
   state_t        state_next;

   logic          hdr_idx_reg;       // 0: expecting count low byte, 1: high byte
   logic [7:0]    hdr_lo_reg;
   logic [15:0]   count_reg;
   logic [1:0]    byte_idx_reg;      // byte position within the current word
   logic [31:0]   word_reg;
   logic [15:0]   words_loaded_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    xor_reg;
`endif

   logic          accept;
   logic          start_ok;
   logic [15:0]   header_n;
   logic          last_word;
   logic [ADDR_WIDTH-1:0] addr_offset;

   assign accept   = byte_valid && byte_ready;
   assign start_ok = start && ((state_reg == ST_IDLE) ||
                               (state_reg == ST_DONE) ||
                               (state_reg == ST_ERROR));

   // Full count as seen while the high header byte is on the bus.
   assign header_n  = {byte_data, hdr_lo_reg};
   assign last_word = (({1'b0, words_loaded_reg} + 17'd1) == {1'b0, count_reg});

   // Index*4 is truncated or extended to the address width. The add wraps modulo 2^ADDR_WIDTH.
   assign addr_offset = ADDR_WIDTH'({words_loaded_reg, 2'b00});

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_ok) begin
               state_next = ST_HDR;
            end
         end
         ST_HDR: begin
            if (accept && hdr_idx_reg) begin
               if (header_n == 16'd0) begin
                  state_next = ST_AFTER_LAST;
               end else if ({1'b0, header_n} > DEPTH_LIMIT) begin
                  state_next = ST_ERROR;
               end else begin
                  state_next = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (accept && (byte_idx_reg == 2'd3)) begin
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_next = last_word ? ST_AFTER_LAST : ST_LOAD;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) begin
               state_next = (byte_data == xor_reg) ? ST_DONE : ST_ERROR;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. These are decoded from state only, so reset sets them at once.
   // ---------------------------------------------------------------------------
   always_comb begin
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      case (state_reg)
         ST_HDR, ST_LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         ST_WRITE: begin
            mem_we = 1'b1;
            busy   = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
`endif
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         ST_ERROR: begin
            error = 1'b1;
         end
         default: begin
            byte_ready = 1'b0;
         end
      endcase
   end

   assign mem_addr     = BASE_ADDR + addr_offset;
   assign mem_wdata    = word_reg;
   assign words_loaded = words_loaded_reg;

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr_idx_reg      <= 1'b0;
         hdr_lo_reg       <= 8'd0;
         count_reg        <= 16'd0;
         byte_idx_reg     <= 2'd0;
         word_reg         <= 32'd0;
         words_loaded_reg <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_reg          <= 8'd0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_ok) begin
                  hdr_idx_reg      <= 1'b0;
                  byte_idx_reg     <= 2'd0;
                  words_loaded_reg <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_reg          <= 8'd0;
`endif
               end
            end
            ST_HDR: begin
               if (accept) begin
                  if (!hdr_idx_reg) begin
                     hdr_lo_reg  <= byte_data;
                     hdr_idx_reg <= 1'b1;
                  end else begin
                     count_reg <= header_n;
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  // Little-endian assembly: every new byte enters at the top.
                  // After four bytes, the first byte received is in bits [7:0].
                  word_reg     <= {byte_data, word_reg[31:8]};
                  byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_reg      <= xor_reg ^ byte_data;
`endif
               end
            end
            ST_WRITE: begin
               words_loaded_reg <= words_loaded_reg + 16'd1;
            end
            default: begin
               hdr_idx_reg <= hdr_idx_reg;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0400;

   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int total = 0;
   int bad   = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   imem_loader #(
      .ADDR_WIDTH(AW),
      .MEM_DEPTH (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Capture every memory write, one entry per cycle with mem_we high.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: XOR of all data bytes.
   function automatic logic [7:0] xor_of(input word_q_t w);
      logic [7:0] x = 8'h00;
      foreach (w[i]) x = x ^ w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
      return x;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_mem_we"},     32'(mem_we),     32'd0);
      check({tag, "_mem_addr"},   mem_addr,        BASE);
      check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
      check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_error"},      32'(error),      32'd0);
      check({tag, "_words"},      32'(words_loaded), 32'd0);
   endtask

   // Present one byte, hold it until accepted; returns at posedge+1 of the accept edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         n++;
         if (n > 50) begin
            check("byte_ready_timeout", 32'(byte_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         send_byte(w[8*k +: 8]);
      end
   endtask

   task automatic begin_load();
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Header, data words, and the checksum byte when the feature is built in.
   task automatic send_image(input word_q_t w, input int gap_max, input bit bad_sum);
      logic [15:0] n;
      n = 16'(w.size());
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      if (w.size() > DEPTH) return;
      foreach (w[i]) send_word(w[i], gap_max);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(xor_of(w) ^ (bad_sum ? 8'h01 : 8'h00));
`else
      if (bad_sum) $display("note: checksum not built, bad_sum ignored");
`endif
   endtask

   // Wait for the load to end, then compare status and writes with the model.
   task automatic expect_result(input string tag, input word_q_t w, input bit exp_done,
                                input int exp_wl, input int exp_nwr);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done || error) && n < 20);
      tick();
      check({tag, "_done"},     32'(done),         32'(exp_done));
      check({tag, "_error"},    32'(error),        32'(!exp_done));
      check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'(!exp_done));
      check({tag, "_busy"},     32'(busy),         32'd0);
      check({tag, "_words"},    32'(words_loaded), 32'(exp_wl));
      check({tag, "_nwrites"},  32'(wr_addr_q.size()), 32'(exp_nwr));
      for (int i = 0; i < wr_addr_q.size() && i < exp_nwr; i++) begin
         check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
         check($sformatf("%s_data%0d", tag, i), wr_data_q[i], w[i]);
      end
      $display("load %s: N=%0d done=%0b error=%0b writes=%0d", tag, w.size(), done, error,
               wr_addr_q.size());
   endtask

   initial begin
      word_q_t w;
      logic [31:0] wd;
      int k;
      int cyc;
      bit acc;

      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) tick();
      check_reset_values("rst");
      reset = 1'b0;
      tick();

      // 1: two-word directed image
      w = {32'h0000_0013, 32'h0010_0093};
      begin_load();
      send_image(w, 0, 1'b0);
      expect_result("two_word", w, 1'b1, 2, 2);

      // 2: count above depth
      w.delete();
      for (int i = 0; i < DEPTH + 1; i++) w.push_back(32'(i));
      begin_load();
      send_image(w, 0, 1'b0);
      expect_result("too_big", w, 1'b0, 0, 0);

      // 3: empty image
      w.delete();
      begin_load();
      send_image(w, 0, 1'b0);
      expect_result("empty", w, 1'b1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin_load();
      send_image(w, 0, 1'b1);
      expect_result("empty_badsum", w, 1'b0, 0, 0);
`endif

      // 4a: byte_valid toggling every cycle on a one-word load
      wd = $urandom();
      w  = {wd};
      begin_load();
      send_byte(8'h01);
      send_byte(8'h00);
      k = 0;
      cyc = 0;
      while (k < 4 && cyc < 64) begin
         byte_valid = (cyc % 2 == 0);
         byte_data  = wd[8*k +: 8];
         @(negedge clk);
         acc = byte_valid && byte_ready;
         tick();
         if (acc) k++;
         cyc++;
      end
      byte_valid = 1'b0;
      check("toggle_bytes", 32'(k), 32'd4);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(xor_of(w));
`endif
      expect_result("toggle", w, 1'b1, 1, 1);

      // 4b: a byte offered during the write cycle is held, then taken
      w = {$urandom(), $urandom()};
      begin_load();
      send_byte(8'h02);
      send_byte(8'h00);
      send_word(w[0], 0);
      byte_valid = 1'b1;
      byte_data  = w[1][7:0];
      @(negedge clk);
      check("wr_cycle_mem_we", 32'(mem_we), 32'd1);
      check("wr_cycle_ready",  32'(byte_ready), 32'd0);
      tick();
      @(negedge clk);
      check("after_wr_ready",  32'(byte_ready), 32'd1);
      tick();
      byte_valid = 1'b0;
      for (int b = 1; b < 4; b++) send_byte(w[1][8*b +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(xor_of(w));
`endif
      expect_result("held_byte", w, 1'b1, 2, 2);

      // 5: reset after two bytes of word 0
      w = {$urandom()};
      begin_load();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'h55);
      reset = 1'b1;
      #1;
      check_reset_values("midrst");
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("midrst_nwrites", 32'(wr_addr_q.size()), 32'd0);
      check("midrst_hold", 32'(cpu_hold), 32'd1);
      begin_load();
      send_image(w, 1, 1'b0);
      expect_result("after_rst", w, 1'b1, 1, 1);

      // 6: start during LOAD is ignored
      w = {$urandom(), $urandom(), $urandom()};
      begin_load();
      send_byte(8'h03);
      send_byte(8'h00);
      send_word(w[0], 0);
      send_byte(w[1][7:0]);
      send_byte(w[1][15:8]);
      start = 1'b1;
      tick();
      start = 1'b0;
      send_byte(w[1][23:16]);
      send_byte(w[1][31:24]);
      send_word(w[2], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(xor_of(w));
`endif
      expect_result("start_in_load", w, 1'b1, 3, 3);

      // 6b: start in DONE reloads
      begin_load();
      check("reload_busy",  32'(busy),         32'd1);
      check("reload_hold",  32'(cpu_hold),     32'd1);
      check("reload_words", 32'(words_loaded), 32'd0);
      check("reload_done",  32'(done),         32'd0);
      w = {$urandom(), $urandom()};
      send_image(w, 2, 1'b0);
      expect_result("reload", w, 1'b1, 2, 2);

      // Boundary: N == MEM_DEPTH
      w.delete();
      for (int i = 0; i < DEPTH; i++) w.push_back($urandom());
      begin_load();
      send_image(w, 0, 1'b0);
      expect_result("full_depth", w, 1'b1, DEPTH, DEPTH);

      // Random images with random gaps
      for (int r = 0; r < 8; r++) begin
         w.delete();
         for (int i = 0; i < $urandom_range(12, 1); i++) w.push_back($urandom());
         begin_load();
         send_image(w, 2, 1'b0);
         expect_result($sformatf("rand%0d", r), w, 1'b1, w.size(), w.size());
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      w = {$urandom(), $urandom(), $urandom()};
      begin_load();
      send_image(w, 1, 1'b1);
      expect_result("badsum", w, 1'b0, 3, 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
